// File: rtl/router_fsm_if.sv
// Router FSM bus: packet source handshake, FIFO status and register-block flags in,
// state strobes and stall out. The FSM uses the slave modport; the driving side uses master.
// The addr_err signal exists only when ROUTER_FSM_ADDR_DROP_EN is defined.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
    logic       wait_timeout;
`ifdef ROUTER_FSM_ADDR_DROP_EN
    logic       addr_err;
`endif

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  rst_int_reg, write_enb_reg, busy, wait_timeout
`ifdef ROUTER_FSM_ADDR_DROP_EN
        , input addr_err
`endif
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output rst_int_reg, write_enb_reg, busy, wait_timeout
`ifdef ROUTER_FSM_ADDR_DROP_EN
        , output addr_err
`endif
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router (Moore FSM).
// Decodes the header address, throttles the source via busy, and sequences the
// load strobes through header, payload, parity and FIFO-full recovery.
// Optional feature: define ROUTER_FSM_ADDR_DROP_EN to add a DROP state that swallows
// packets addressed to 3 and flags them on addr_err.
// Note: resetn is a synchronous ACTIVE-HIGH reset despite its name.
module router_fsm #(
    parameter int CNT_W      = 8,
    parameter int WAIT_LIMIT = 255   // 0 disables the WAIT_TILL_EMPTY abort
) (
    input  logic        clk,
    input  logic        resetn,
    router_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        ST_DA   = 4'd0,
        ST_LFD  = 4'd1,
        ST_LD   = 4'd2,
        ST_LP   = 4'd3,
        ST_CPE  = 4'd4,
        ST_FFS  = 4'd5,
        ST_LAF  = 4'd6,
        ST_WTE  = 4'd7
`ifdef ROUTER_FSM_ADDR_DROP_EN
        , ST_DROP = 4'd8
`endif
    } state_t;

    localparam bit               LIMIT_EN = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_reg, state_next;
    logic [1:0]       addr_reg, addr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;
`ifdef ROUTER_FSM_ADDR_DROP_EN
    logic             addr_err_reg, addr_err_next;
`endif

    // Address 3 maps to a tied-off slot so indexing by a 2-bit address is always in range.
    logic [3:0] empty_vec;
    logic [3:0] srst_vec;
    assign empty_vec = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign srst_vec  = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    logic hdr_valid, hdr_empty, sel_empty, sel_srst;
    assign hdr_valid = bus.pkt_valid && (bus.data_in != 2'd3);
    assign hdr_empty = empty_vec[bus.data_in];
    assign sel_empty = empty_vec[addr_reg];
    assign sel_srst  = srst_vec[addr_reg];

    // State, latched address, wait counter and one-cycle flags.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg    <= ST_DA;
            addr_reg     <= 2'd0;
            cnt_reg      <= '0;
            timeout_reg  <= 1'b0;
`ifdef ROUTER_FSM_ADDR_DROP_EN
            addr_err_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
            timeout_reg  <= timeout_next;
`ifdef ROUTER_FSM_ADDR_DROP_EN
            addr_err_reg <= addr_err_next;
`endif
        end
    end

    // Next-state logic; a soft reset of the selected FIFO overrides every arc outside DA.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        cnt_next      = '0;          // cleared everywhere except while staying in WTE
        timeout_next  = 1'b0;
`ifdef ROUTER_FSM_ADDR_DROP_EN
        addr_err_next = 1'b0;
`endif
        case (state_reg)
            ST_DA: begin
                if (hdr_valid) begin
                    addr_next  = bus.data_in;
                    state_next = hdr_empty ? ST_LFD : ST_WTE;
                end
`ifdef ROUTER_FSM_ADDR_DROP_EN
                else if (bus.pkt_valid) begin
                    addr_next     = bus.data_in;
                    state_next    = ST_DROP;
                    addr_err_next = 1'b1;
                end
`endif
            end
            ST_LFD: state_next = ST_LD;
            ST_LD: begin
                if (bus.fifo_full)       state_next = ST_FFS;
                else if (!bus.pkt_valid) state_next = ST_LP;
            end
            ST_LP:  state_next = ST_CPE;
            ST_CPE: state_next = bus.fifo_full ? ST_FFS : ST_DA;
            ST_FFS: state_next = bus.fifo_full ? ST_FFS : ST_LAF;
            ST_LAF: begin
                if (bus.parity_done)           state_next = ST_DA;
                else if (bus.low_packet_valid) state_next = ST_LP;
                else                           state_next = ST_LD;
            end
            ST_WTE: begin
                // Empty wins over a timeout landing on the same cycle.
                if (sel_empty) begin
                    state_next = ST_LFD;
                end else if (LIMIT_EN && (cnt_reg == LIMIT_M1)) begin
                    state_next   = ST_DA;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                end
            end
`ifdef ROUTER_FSM_ADDR_DROP_EN
            ST_DROP: state_next = bus.pkt_valid ? ST_DROP : ST_DA;
`endif
            default: state_next = ST_DA;
        endcase

        if ((state_reg != ST_DA) && sel_srst) begin
            state_next   = ST_DA;
            cnt_next     = '0;
            timeout_next = 1'b0;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign bus.detect_add    = (state_reg == ST_DA);
    assign bus.lfd_state     = (state_reg == ST_LFD);
    assign bus.ld_state      = (state_reg == ST_LD);
    assign bus.laf_state     = (state_reg == ST_LAF);
    assign bus.full_state    = (state_reg == ST_FFS);
    assign bus.rst_int_reg   = (state_reg == ST_CPE);
    assign bus.write_enb_reg = (state_reg == ST_LFD) || (state_reg == ST_LD) ||
                               (state_reg == ST_LP)  || (state_reg == ST_LAF);
`ifdef ROUTER_FSM_ADDR_DROP_EN
    assign bus.busy          = !((state_reg == ST_DA) || (state_reg == ST_LD) ||
                                 (state_reg == ST_DROP));
    assign bus.addr_err      = addr_err_reg;
`else
    assign bus.busy          = !((state_reg == ST_DA) || (state_reg == ST_LD));
`endif
    assign bus.wait_timeout  = timeout_reg;

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: a directed vector table followed by random
// stimulus checked against a packet-phase reference model.
module tb_router_fsm;

    localparam int WAIT_LIMIT = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    router_fsm_if bus();

    router_fsm #(.CNT_W(8), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef enum int {P_IDLE, P_FIRST, P_PAYLOAD, P_PARITY, P_CHECK,
                      P_FULL, P_AFTER_FULL, P_WAIT, P_DROP} phase_t;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] emp;   // {e2,e1,e0}
        logic [2:0] sr;    // {s2,s1,s0}
        logic       pd;
        logic       lpv;
        phase_t     exp_p;
        logic       exp_to;
        logic       exp_ae;
    } vec_t;

`ifdef ROUTER_FSM_ADDR_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    // Reference model state: packet phase, selected FIFO, cycles spent waiting.
    phase_t     m_p;
    logic [1:0] m_addr;
    int         m_waited;

    function automatic vec_t mkv(input logic rst, input logic pv, input logic [1:0] din,
                                 input logic full, input logic [2:0] emp, input logic [2:0] sr,
                                 input logic pd, input logic lpv, input phase_t p,
                                 input logic to, input logic ae);
        vec_t v;
        v.rst = rst; v.pv = pv; v.din = din; v.full = full; v.emp = emp; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.exp_p = p; v.exp_to = to; v.exp_ae = ae;
        return v;
    endfunction

    // Expected strobes for each packet phase.
    function automatic logic [8:0] outs_of(input phase_t p, input logic to);
        logic we, bsy;
        we  = (p == P_FIRST) || (p == P_PAYLOAD) || (p == P_PARITY) || (p == P_AFTER_FULL);
        bsy = !((p == P_IDLE) || (p == P_PAYLOAD) || (p == P_DROP));
        return {p == P_IDLE, p == P_FIRST, p == P_PAYLOAD, p == P_AFTER_FULL,
                p == P_FULL, p == P_CHECK, we, bsy, to};
    endfunction

    function automatic logic [8:0] act_outs();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.wait_timeout};
    endfunction

    task automatic drive(input vec_t v);
        resetn               = v.rst;
        bus.pkt_valid        = v.pv;
        bus.data_in          = v.din;
        bus.fifo_full        = v.full;
        bus.fifo_empty_0     = v.emp[0];
        bus.fifo_empty_1     = v.emp[1];
        bus.fifo_empty_2     = v.emp[2];
        bus.soft_reset_0     = v.sr[0];
        bus.soft_reset_1     = v.sr[1];
        bus.soft_reset_2     = v.sr[2];
        bus.parity_done      = v.pd;
        bus.low_packet_valid = v.lpv;
    endtask

    // Apply one vector for one clock edge and compare the outputs just after it.
    task automatic run_vec(input vec_t v, input string name, input int idx);
        logic [8:0] got, want;
        drive(v);
        @(posedge clk);
        #1;
        got  = act_outs();
        want = outs_of(v.exp_p, v.exp_to);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s #%0d outs: got %b expected %b (phase %s)",
                     name, idx, got, want, v.exp_p.name());
        end
`ifdef ROUTER_FSM_ADDR_DROP_EN
        n_checks++;
        if (bus.addr_err !== v.exp_ae) begin
            n_fail++;
            $display("FAIL %s #%0d addr_err: got %b expected %b", name, idx, bus.addr_err, v.exp_ae);
        end
`endif
    endtask

    // Advance the reference model by one clock and record its expectations in v.
    task automatic model_step(inout vec_t v);
        logic [3:0] emp4, sr4;
        phase_t     nxt;
        logic       to, ae;
        emp4 = {1'b0, v.emp};
        sr4  = {1'b0, v.sr};
        to = 1'b0; ae = 1'b0;
        if (v.rst) begin
            m_p = P_IDLE; m_addr = 2'd0; m_waited = 0;
        end else begin
            nxt = m_p;
            case (m_p)
                P_IDLE: begin
                    if (v.pv && v.din != 2'd3) begin
                        nxt = emp4[v.din] ? P_FIRST : P_WAIT;
                    end else if (v.pv && DROP_EN) begin
                        nxt = P_DROP; ae = 1'b1;
                    end
                end
                P_FIRST:      nxt = P_PAYLOAD;
                P_PAYLOAD:    nxt = v.full ? P_FULL : (!v.pv ? P_PARITY : P_PAYLOAD);
                P_PARITY:     nxt = P_CHECK;
                P_CHECK:      nxt = v.full ? P_FULL : P_IDLE;
                P_FULL:       nxt = v.full ? P_FULL : P_AFTER_FULL;
                P_AFTER_FULL: nxt = v.pd ? P_IDLE : (v.lpv ? P_PARITY : P_PAYLOAD);
                P_WAIT: begin
                    m_waited++;
                    if (emp4[m_addr]) nxt = P_FIRST;
                    else if (m_waited == WAIT_LIMIT) begin nxt = P_IDLE; to = 1'b1; end
                end
                P_DROP:       nxt = v.pv ? P_DROP : P_IDLE;
                default:      nxt = P_IDLE;
            endcase
            if (m_p != P_IDLE && sr4[m_addr]) begin nxt = P_IDLE; to = 1'b0; end
            if (m_p == P_IDLE && nxt != P_IDLE) m_addr = v.din;
            if (nxt != P_WAIT) m_waited = 0;
            m_p = nxt;
        end
        v.exp_p = m_p; v.exp_to = to; v.exp_ae = ae;
    endtask

    initial begin
        phase_t dp;
        dp = DROP_EN ? P_DROP : P_IDLE;

        // Reset
        repeat (2) vecs.push_back(mkv(1,0,0,0,3'b000,0,0,0,P_IDLE,0,0));
        // Address 1, empty FIFO, four payload cycles
        vecs.push_back(mkv(0,1,1,0,3'b010,0,0,0,P_FIRST,0,0));
        repeat (4) vecs.push_back(mkv(0,1,1,0,3'b010,0,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,0,1,0,3'b010,0,0,0,P_PARITY,0,0));
        vecs.push_back(mkv(0,0,1,0,3'b010,0,0,0,P_CHECK,0,0));
        vecs.push_back(mkv(0,0,1,0,3'b010,0,0,0,P_IDLE,0,0));
        // FIFO full for three cycles, recovery with parity_done
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_FIRST,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_PAYLOAD,0,0));
        repeat (3) vecs.push_back(mkv(0,1,0,1,3'b001,0,0,0,P_FULL,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_AFTER_FULL,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,1,0,P_IDLE,0,0));
        // LAF -> LP on low_packet_valid, CPE -> FFS, LAF -> LD
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_FIRST,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,1,0,1,3'b001,0,0,0,P_FULL,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,1,P_AFTER_FULL,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,1,P_PARITY,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,0,P_CHECK,0,0));
        vecs.push_back(mkv(0,0,0,1,3'b001,0,0,0,P_FULL,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_AFTER_FULL,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,0,P_PARITY,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,0,P_CHECK,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,0,P_IDLE,0,0));
        // parity_done beats low_packet_valid in LAF
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_FIRST,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,0,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,1,0,1,3'b001,0,0,0,P_FULL,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,0,0,P_AFTER_FULL,0,0));
        vecs.push_back(mkv(0,0,0,0,3'b001,0,1,1,P_IDLE,0,0));
        // Address 2 not empty: four WTE cycles then timeout pulse
        vecs.push_back(mkv(0,1,2,0,3'b000,0,0,0,P_WAIT,0,0));
        repeat (3) vecs.push_back(mkv(0,1,2,0,3'b000,0,0,0,P_WAIT,0,0));
        vecs.push_back(mkv(0,0,2,0,3'b000,0,0,0,P_IDLE,1,0));
        vecs.push_back(mkv(0,0,2,0,3'b000,0,0,0,P_IDLE,0,0));
        // Again, FIFO 2 empties on the fourth WTE cycle: LFD, no pulse
        vecs.push_back(mkv(0,1,2,0,3'b000,0,0,0,P_WAIT,0,0));
        repeat (3) vecs.push_back(mkv(0,1,2,0,3'b000,0,0,0,P_WAIT,0,0));
        vecs.push_back(mkv(0,1,2,0,3'b100,0,0,0,P_FIRST,0,0));
        vecs.push_back(mkv(0,1,2,0,3'b100,0,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,0,2,0,3'b100,0,0,0,P_PARITY,0,0));
        vecs.push_back(mkv(0,0,2,0,3'b100,0,0,0,P_CHECK,0,0));
        vecs.push_back(mkv(0,0,2,0,3'b100,0,0,0,P_IDLE,0,0));
        // Soft reset: other FIFO ignored, selected FIFO aborts, ignored in DA
        vecs.push_back(mkv(0,1,0,0,3'b001,3'b000,0,0,P_FIRST,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,3'b000,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,3'b010,0,0,P_PAYLOAD,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,3'b001,0,0,P_IDLE,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,3'b001,0,0,P_FIRST,0,0));
        vecs.push_back(mkv(0,1,0,0,3'b001,3'b000,0,0,P_PAYLOAD,0,0));
        // Reset mid-packet
        vecs.push_back(mkv(1,1,0,0,3'b001,3'b000,0,0,P_IDLE,0,0));
        // Soft reset while waiting: back to DA without timeout pulse
        vecs.push_back(mkv(0,1,1,0,3'b000,3'b000,0,0,P_WAIT,0,0));
        vecs.push_back(mkv(0,1,1,0,3'b000,3'b010,0,0,P_IDLE,0,0));
        // Address 3 for five cycles
        vecs.push_back(mkv(0,1,3,0,3'b000,0,0,0,dp,0,DROP_EN));
        repeat (4) vecs.push_back(mkv(0,1,3,0,3'b000,0,0,0,dp,0,0));
        vecs.push_back(mkv(0,0,3,0,3'b000,0,0,0,P_IDLE,0,0));

        foreach (vecs[i]) run_vec(vecs[i], "table", i);

        // Random stimulus against the reference model
        m_p = P_IDLE; m_addr = 2'd0; m_waited = 0;
        for (int i = 0; i < 4000; i++) begin
            vec_t v;
            v.rst  = (i == 0) || ($urandom_range(0, 99) == 0);
            v.pv   = ($urandom_range(0, 9) < 7);
            v.din  = 2'($urandom_range(0, 3));
            v.full = ($urandom_range(0, 9) < 3);
            v.emp  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
            v.sr   = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
            v.pd   = ($urandom_range(0, 4) == 0);
            v.lpv  = ($urandom_range(0, 4) == 0);
            model_step(v);
            run_vec(v, "random", i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
